// File: rtl/bsg_fifo_periodic_sched_pkg.sv
// ============================================================================
// Module : bsg_fifo_periodic_sched_pkg
// Brief  : Shared helpers for the periodic fast->slow slot scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bsg_fifo_periodic_sched_pkg;

   // Index width that never collapses to zero bits for single-element ranges.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
// ============================================================================
// Module : bsg_counter_clear_up
// Brief  : Up counter with synchronous clear; clear and up together yield 1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_counter_clear_up
   import bsg_fifo_periodic_sched_pkg::*;
#(
   parameter int max_val_p  = 1,
   parameter int init_val_p = 0,
   localparam int ptr_width_lp = safe_clog2(max_val_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic                    up_i,
   output logic [ptr_width_lp-1:0] count_o
);

   logic [ptr_width_lp-1:0] r_count;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_count <= ptr_width_lp'(init_val_p);
      else
         r_count <= (clear_i ? '0 : r_count) + ptr_width_lp'(up_i);
   end

   assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bsg_fifo_periodic_sched_rr.sv
// ============================================================================
// Module : bsg_fifo_periodic_sched_rr
// Brief  : Combinational round-robin pick starting the scan at ptr_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_fifo_periodic_sched_rr
   import bsg_fifo_periodic_sched_pkg::*;
#(
   parameter int els_p = 4,
   localparam int lg_els_lp = safe_clog2(els_p)
) (
   input  logic [els_p-1:0]     v_i,
   input  logic [lg_els_lp-1:0] ptr_i,
   output logic [lg_els_lp-1:0] grant_id_o,
   output logic                 grant_v_o
);

   // Scan farthest-first so the closest valid requester to ptr_i wins last.
   always_comb begin
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      for (int k = els_p - 1; k >= 0; k--) begin
         if (v_i[(int'(ptr_i) + k) % els_p]) begin
            grant_id_o = lg_els_lp'((int'(ptr_i) + k) % els_p);
            grant_v_o  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bsg_fifo_periodic_sched.sv
// ============================================================================
// Module : bsg_fifo_periodic_sched
// Brief  : Round-robin scheduler for one fast->slow transfer slot per slow
//          period. Optional macro BSG_FIFO_PERIODIC_SCHED_HOLD_EN keeps a
//          stalled grant fixed until it transfers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_fifo_periodic_sched
   import bsg_fifo_periodic_sched_pkg::*;
#(
   parameter int els_p   = 4,
   parameter int width_p = 32,
   parameter int ratio_p = 2,
   localparam int lg_els_lp = safe_clog2(els_p),
   localparam int cnt_w_lp  = safe_clog2(ratio_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         yumi_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     ready_and_i,
   output logic                     slot_o,
   output logic [lg_els_lp-1:0]     grant_id_o
);

   logic [cnt_w_lp-1:0]  w_cnt;
   logic                 w_at_max;
   logic                 w_slot;
   logic [lg_els_lp-1:0] r_ptr;
   logic [lg_els_lp-1:0] w_rr_id;
   logic                 w_rr_v;
   logic [lg_els_lp-1:0] w_grant;
   logic                 w_v;
   logic                 w_xfer;

   assign w_at_max = (w_cnt == cnt_w_lp'(ratio_p - 1));

   bsg_counter_clear_up #(
      .max_val_p  (ratio_p - 1),
      .init_val_p (0)
   ) u_phase (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (w_at_max),
      .up_i    (~w_at_max),
      .count_o (w_cnt)
   );

   bsg_fifo_periodic_sched_rr #(
      .els_p (els_p)
   ) u_rr (
      .v_i        (v_i),
      .ptr_i      (r_ptr),
      .grant_id_o (w_rr_id),
      .grant_v_o  (w_rr_v)
   );

   assign w_slot = w_at_max & ~reset_i;
   assign w_v    = w_slot & w_rr_v;
   assign w_xfer = w_v & ready_and_i;

`ifdef BSG_FIFO_PERIODIC_SCHED_HOLD_EN
   logic                 r_hold_v;
   logic [lg_els_lp-1:0] r_hold_id;

   // A stalled offer is pinned so the downstream sees a stable valid/data.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_hold_v  <= 1'b0;
         r_hold_id <= '0;
      end else if (w_xfer) begin
         r_hold_v  <= 1'b0;
      end else if (w_v) begin
         r_hold_v  <= 1'b1;
         r_hold_id <= w_grant;
      end
   end

   assign w_grant = r_hold_v ? r_hold_id : w_rr_id;
`else
   assign w_grant = w_rr_id;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_ptr <= '0;
      else if (w_xfer)
         r_ptr <= (w_grant == lg_els_lp'(els_p - 1)) ? '0 : w_grant + lg_els_lp'(1);
   end

   assign slot_o     = w_slot;
   assign v_o        = w_v;
   assign data_o     = data_i[int'(w_grant)*width_p +: width_p];
   assign yumi_o     = w_xfer ? (els_p'(1) << w_grant) : '0;
   assign grant_id_o = reset_i ? '0 : w_grant;

endmodule

`default_nettype wire

// File: tb/tb_bsg_fifo_periodic_sched.sv
// ============================================================================
// Module : tb_bsg_fifo_periodic_sched
// Brief  : Bench for three scheduler instances (ratio 2, 4, 1) against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_fifo_periodic_sched;

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic       rdy;
      logic       slot;
      logic       vo;
      logic [3:0] yumi;
   } tv_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   v_in   [3];
   logic         rdy_in [3];
   logic [127:0] data_in;
   logic [3:0]   yumi_a [3];
   logic         v_a    [3];
   logic [31:0]  dat_a  [3];
   logic         slot_a [3];
   logic [1:0]   gid_a  [3];

   int vectors    = 0;
   int miscompares = 0;

   int m_cnt [3];
   int m_ptr [3];
   int m_g   [3];
   int m_hid [3];
   bit m_hv  [3];
   bit m_ev  [3];
   bit m_tr  [3];

   always #5 clk = ~clk;

   bsg_fifo_periodic_sched #(.els_p(4), .width_p(32), .ratio_p(2)) dut_r2 (
      .clk_i(clk), .reset_i(rst), .v_i(v_in[0]), .data_i(data_in), .yumi_o(yumi_a[0]),
      .v_o(v_a[0]), .data_o(dat_a[0]), .ready_and_i(rdy_in[0]), .slot_o(slot_a[0]),
      .grant_id_o(gid_a[0]));

   bsg_fifo_periodic_sched #(.els_p(4), .width_p(32), .ratio_p(4)) dut_r4 (
      .clk_i(clk), .reset_i(rst), .v_i(v_in[1]), .data_i(data_in), .yumi_o(yumi_a[1]),
      .v_o(v_a[1]), .data_o(dat_a[1]), .ready_and_i(rdy_in[1]), .slot_o(slot_a[1]),
      .grant_id_o(gid_a[1]));

   bsg_fifo_periodic_sched #(.els_p(4), .width_p(32), .ratio_p(1)) dut_r1 (
      .clk_i(clk), .reset_i(rst), .v_i(v_in[2]), .data_i(data_in), .yumi_o(yumi_a[2]),
      .v_o(v_a[2]), .data_o(dat_a[2]), .ready_and_i(rdy_in[2]), .slot_o(slot_a[2]),
      .grant_id_o(gid_a[2]));

   function automatic int ratio_of(input int d);
      case (d)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: slot is the last fast cycle of each period, grant is the
   // first valid requester scanning from the pointer.
   task automatic model_eval();
      for (int d = 0; d < 3; d++) begin
         int       g;
         bit       found;
         bit       slot;
         logic [3:0] ey;
         g     = 0;
         found = 0;
         slot  = !rst && (m_cnt[d] == ratio_of(d) - 1);
         for (int k = 0; k < 4; k++) begin
            if (!found && v_in[d][(m_ptr[d] + k) % 4]) begin
               g     = (m_ptr[d] + k) % 4;
               found = 1;
            end
         end
`ifdef BSG_FIFO_PERIODIC_SCHED_HOLD_EN
         if (m_hv[d]) g = m_hid[d];
`endif
         m_g[d]  = g;
         m_ev[d] = slot && (v_in[d] != 4'b0);
         m_tr[d] = m_ev[d] && rdy_in[d];
         ey      = m_tr[d] ? (4'b0001 << g) : 4'b0000;
         chk($sformatf("slot[%0d]", d), 32'(slot_a[d]), 32'(slot));
         chk($sformatf("v_o[%0d]", d), 32'(v_a[d]), 32'(m_ev[d]));
         chk($sformatf("yumi[%0d]", d), 32'(yumi_a[d]), 32'(ey));
         if (m_ev[d]) begin
            chk($sformatf("data[%0d]", d), dat_a[d], data_in[g*32 +: 32]);
            chk($sformatf("gid[%0d]", d), 32'(gid_a[d]), 32'(g));
         end else if (rst) begin
            chk($sformatf("gid_rst[%0d]", d), 32'(gid_a[d]), 32'd0);
         end
      end
   endtask

   task automatic model_update();
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_cnt[d] = 0;
            m_ptr[d] = 0;
            m_hv[d]  = 0;
         end else begin
            m_cnt[d] = (m_cnt[d] + 1) % ratio_of(d);
            if (m_tr[d]) begin
               m_ptr[d] = (m_g[d] + 1) % 4;
               m_hv[d]  = 0;
            end
`ifdef BSG_FIFO_PERIODIC_SCHED_HOLD_EN
            else if (m_ev[d]) begin
               m_hv[d]  = 1;
               m_hid[d] = m_g[d];
            end
`endif
         end
      end
   endtask

   task automatic eval();
      #1;
      model_eval();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic cyc();
      eval();
      adv();
   endtask

   task automatic set_all(input logic r, input logic [3:0] v, input logic rd);
      rst = r;
      for (int d = 0; d < 3; d++) begin
         v_in[d]   = v;
         rdy_in[d] = rd;
      end
   endtask

   initial begin
      tv_t tv [11];
      logic [3:0] exp_y;

      tv[0] = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000};
      for (int c = 0; c < 10; c++)
         tv[c+1] = '{1'b0, 4'hF, 1'b1, 1'(c % 2), 1'(c % 2), 4'b0000};
      tv[2].yumi  = 4'b0001;
      tv[4].yumi  = 4'b0010;
      tv[6].yumi  = 4'b0100;
      tv[8].yumi  = 4'b1000;
      tv[10].yumi = 4'b0001;

      for (int d = 0; d < 3; d++) begin
         m_cnt[d] = 0; m_ptr[d] = 0; m_hv[d] = 0; m_hid[d] = 0;
         m_g[d] = 0; m_ev[d] = 0; m_tr[d] = 0;
      end
      data_in = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
      set_all(1'b1, 4'h0, 1'b0);
      @(negedge clk);

      // Fairness on the ratio-2 instance, all requesters valid.
      for (int i = 0; i < 11; i++) begin
         set_all(tv[i].rst, tv[i].v, tv[i].rdy);
         eval();
         chk($sformatf("tbl%0d_slot", i), 32'(slot_a[0]), 32'(tv[i].slot));
         chk($sformatf("tbl%0d_v", i), 32'(v_a[0]), 32'(tv[i].vo));
         chk($sformatf("tbl%0d_yumi", i), 32'(yumi_a[0]), 32'(tv[i].yumi));
         adv();
      end

      // Reset held three cycles on ratio 4, then first slot at cycle 3.
      for (int i = 0; i < 3; i++) begin
         set_all(1'b1, 4'hF, 1'b1);
         eval();
         chk("rst_v", 32'(v_a[1]), 32'd0);
         chk("rst_yumi", 32'(yumi_a[1]), 32'd0);
         chk("rst_slot", 32'(slot_a[1]), 32'd0);
         adv();
      end
      for (int c = 0; c < 5; c++) begin
         set_all(1'b0, 4'hF, 1'b1);
         eval();
         chk($sformatf("first_slot_c%0d", c), 32'(slot_a[1]), 32'(c == 3));
         adv();
      end

      // Sparse request: only requester 2, then pointer lands on 3.
      set_all(1'b1, 4'h0, 1'b1); cyc();
      set_all(1'b0, 4'b0100, 1'b1); cyc();
      eval();
      chk("sparse_gid", 32'(gid_a[0]), 32'd2);
      chk("sparse_yumi", 32'(yumi_a[0]), 32'b0100);
      adv();
      set_all(1'b0, 4'hF, 1'b1); cyc();
      eval();
      chk("sparse_next_gid", 32'(gid_a[0]), 32'd3);
      adv();

      // Stall for two slots; pointer must not move.
      set_all(1'b1, 4'h0, 1'b0); cyc();
      for (int c = 0; c < 4; c++) begin
         set_all(1'b0, 4'b0011, 1'b0);
         eval();
         if (c % 2 == 1) begin
            chk($sformatf("stall_v_c%0d", c), 32'(v_a[0]), 32'd1);
            chk($sformatf("stall_yumi_c%0d", c), 32'(yumi_a[0]), 32'd0);
            chk($sformatf("stall_gid_c%0d", c), 32'(gid_a[0]), 32'd0);
         end
         adv();
      end
      set_all(1'b0, 4'b0011, 1'b1); cyc();
      eval();
      chk("stall_release_yumi", 32'(yumi_a[0]), 32'b0001);
      adv();

      // Stalled grantee 1 while requester 0 (closer to the pointer) arrives.
      set_all(1'b1, 4'h0, 1'b0); cyc();
      set_all(1'b0, 4'b0010, 1'b0); cyc();
      eval();
      chk("hold_first_gid", 32'(gid_a[0]), 32'd1);
      adv();
      set_all(1'b0, 4'b0011, 1'b1); cyc();
      eval();
`ifdef BSG_FIFO_PERIODIC_SCHED_HOLD_EN
      exp_y = 4'b0010;
`else
      exp_y = 4'b0001;
`endif
      chk("hold_second_yumi", 32'(yumi_a[0]), 32'(exp_y));
      adv();

      // Ratio 1: every cycle is a slot.
      set_all(1'b1, 4'h0, 1'b1); cyc();
      for (int c = 0; c < 3; c++) begin
         set_all(1'b0, 4'b1001, 1'b1);
         eval();
         exp_y = (c == 1) ? 4'b1000 : 4'b0001;
         chk($sformatf("r1_yumi_c%0d", c), 32'(yumi_a[2]), 32'(exp_y));
         adv();
      end

      // Reset at phase 2 of 4 after one transfer moved the pointer.
      set_all(1'b1, 4'h0, 1'b1); cyc();
      for (int c = 0; c < 6; c++) begin
         set_all(1'b0, 4'hF, 1'b1); cyc();
      end
      set_all(1'b1, 4'hF, 1'b1);
      eval();
      chk("midrst_yumi", 32'(yumi_a[1]), 32'd0);
      chk("midrst_slot", 32'(slot_a[1]), 32'd0);
      adv();
      for (int c = 0; c < 4; c++) begin
         set_all(1'b0, 4'hF, 1'b1);
         eval();
         chk($sformatf("midrst_after_c%0d", c), 32'(yumi_a[1]), 32'((c == 3) ? 4'b0001 : 4'b0000));
         adv();
      end

      // Randomized traffic obeying valid-stable requests.
      set_all(1'b1, 4'h0, 1'b0); cyc();
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int d = 0; d < 3; d++) begin
            v_in[d]   = v_in[d] | 4'($urandom & $urandom);
            rdy_in[d] = ($urandom_range(0, 3) != 0);
         end
         for (int w = 0; w < 4; w++) data_in[w*32 +: 32] = $urandom;
         cyc();
         for (int d = 0; d < 3; d++)
            if (m_tr[d]) v_in[d] = v_in[d] & ~(4'b0001 << m_g[d]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
